rr_mux_pipe: RTL and testbench

- Parametrised N-channel, WIDTH-bit multiplexer; successor to the 1-bit 2:1 combinational mux.
- Adds a registered output stage, valid/ready handshakes on every input and on the output, and two selection modes: fixed select, or round-robin arbitration among requesting channels.
- Sits between several producer streams and one consumer, for example to merge datapath results onto a single bus.

---
 rtl/rr_mux_pipe.sv | 115 +++++++++++
 tb/tb_rr_mux_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_pipe.sv
// rr_mux_pipe: N-channel, WIDTH-bit multiplexer with a registered output stage.
// Input and output handshakes are valid/ready. Two ways of picking a channel:
// a fixed select index (mode = 0), or round-robin among the requesting
// channels (mode = 1).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_data    N*WIDTH packed channel data; channel i is [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel accept (one-hot or zero)
//   mode       0 = fixed select, 1 = round-robin
//   select     channel index used in fixed mode
//   out_data   registered output word
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts out_data
//   out_chan   channel that produced out_data
module rr_mux_pipe #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    select,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_chan
);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SELW-1:0]  r_out_chan;
  logic [SELW-1:0]  r_last;

  logic [WIDTH-1:0] w_chan_data [N];
  logic             w_load_en;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_gnt;
  logic [SELW-1:0]  w_scan;
  logic             w_xfer;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // The output register can take a new word when it is empty or draining now.
  assign w_load_en = !r_out_valid || out_ready;

  // Round-robin scans upward from the channel after the last one granted, so the
  // most recent winner has the lowest priority. The first hit wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_scan    = '0;
    if (!mode) begin
      // A select index past the last channel (N not a power of two) grants nothing.
      if (int'(select) < N) begin
        w_gnt_vld = 1'b1;
        w_gnt     = select;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        w_scan = SELW'((int'(r_last) + k) % N);
        if (!w_gnt_vld && in_valid[w_scan]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = w_scan;
        end
      end
    end
  end

  // in_ready is held low while reset is asserted, even though the empty
  // register would otherwise allow a load.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = w_gnt_vld && w_load_en && !rst && (int'(w_gnt) == i);
    end
  end

  assign w_xfer = w_gnt_vld && w_load_en && !rst && in_valid[w_gnt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_last      <= SELW'(N - 1);
    end else if (w_xfer) begin
      // A load in the same cycle as a drain overwrites the word, so valid stays 1.
      r_out_data  <= w_chan_data[w_gnt];
      r_out_chan  <= w_gnt;
      r_out_valid <= 1'b1;
      // Only round-robin grants move the pointer. Fixed-mode traffic leaves it alone.
      if (mode) begin
        r_last <= w_gnt;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_rr_mux_pipe.sv
// tb_rr_mux_pipe: checks rr_mux_pipe in three configurations.
//   u2: N=2, WIDTH=1, the old 2:1 mux.
//   u3: N=3, WIDTH=8, where select can point past the last channel.
//   u4: N=4, WIDTH=8, used for round-robin, sparse requests, backpressure and async reset.
// Each table row drives one cycle of inputs and checks in_ready mid-cycle.
// Words expected to transfer go into a queue at the row and come out of it
// after the clock edge, where they are compared with the registered output.
module tb_rr_mux_pipe;

  typedef struct {
    int         dut;
    bit         rb;
    bit         md;
    logic [1:0] sel;
    logic [3:0] v;
    bit         ordy;
    logic [3:0] rdy;
    bit         x;
    logic [1:0] ch;
    logic [7:0] d;
    logic [7:0] d0;
  } vec_t;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] d;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [1:0] sel;
  logic [3:0] v;
  logic       ordy;
  logic [7:0] d4_d0;

  logic [1:0] r2;
  logic [0:0] od2;
  logic       ov2;
  logic [0:0] oc2;
  logic [2:0] r3;
  logic [7:0] od3;
  logic       ov3;
  logic [1:0] oc3;
  logic [3:0] r4;
  logic [7:0] od4;
  logic       ov4;
  logic [1:0] oc4;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sbq[$];
  vec_t tbl[$];
  logic       m_v;
  logic [7:0] m_d;
  logic [1:0] m_c;

  rr_mux_pipe #(.WIDTH(1), .N(2)) u2 (
    .clk(clk), .rst(rst), .in_data(2'b01), .in_valid(v[1:0]), .in_ready(r2),
    .mode(mode), .select(sel[0:0]), .out_data(od2), .out_valid(ov2),
    .out_ready(ordy), .out_chan(oc2)
  );

  rr_mux_pipe #(.WIDTH(8), .N(3)) u3 (
    .clk(clk), .rst(rst), .in_data({8'hC2, 8'hC1, 8'hC0}), .in_valid(v[2:0]),
    .in_ready(r3), .mode(mode), .select(sel), .out_data(od3), .out_valid(ov3),
    .out_ready(ordy), .out_chan(oc3)
  );

  rr_mux_pipe #(.WIDTH(8), .N(4)) u4 (
    .clk(clk), .rst(rst), .in_data({8'hA3, 8'hA2, 8'hA1, d4_d0}), .in_valid(v),
    .in_ready(r4), .mode(mode), .select(sel), .out_data(od4), .out_valid(ov4),
    .out_ready(ordy), .out_chan(oc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t reached, required finish earlier", $time);
    $fatal(1);
  end

  function automatic vec_t mk(int dut, bit rb, bit md, logic [1:0] s, logic [3:0] vv,
                              bit orr, logic [3:0] rdy, bit x, logic [1:0] ch,
                              logic [7:0] d, logic [7:0] d0);
    vec_t t;
    t.dut = dut; t.rb = rb; t.md = md; t.sel = s; t.v = vv; t.ordy = orr;
    t.rdy = rdy; t.x = x; t.ch = ch; t.d = d; t.d0 = d0;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic read_out(input int dut, output logic ov, output logic [7:0] od,
                          output logic [1:0] oc, output logic [3:0] rdy);
    case (dut)
      2: begin ov = ov2; od = {7'b0, od2}; oc = {1'b0, oc2}; rdy = {2'b0, r2}; end
      3: begin ov = ov3; od = od3; oc = oc3; rdy = {1'b0, r3}; end
      default: begin ov = ov4; od = od4; oc = oc4; rdy = r4; end
    endcase
  endtask

  task automatic model_clear();
    m_v = 1'b0;
    m_d = 8'h00;
    m_c = 2'd0;
    sbq.delete();
  endtask

  task automatic do_reset(input int dut);
    logic ov; logic [7:0] od; logic [1:0] oc; logic [3:0] rdy;
    rst = 1'b1;
    v = 4'h0;
    #2;
    read_out(dut, ov, od, oc, rdy);
    chk($sformatf("u%0d reset out_valid", dut), ov, 1'b0);
    chk($sformatf("u%0d reset out_data", dut), od, 8'h00);
    chk($sformatf("u%0d reset out_chan", dut), oc, 2'd0);
    model_clear();
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic post_edge(input int dut, input bit x, input bit orr, input string nm);
    logic ov; logic [7:0] od; logic [1:0] oc; logic [3:0] rdy;
    exp_t e;
    read_out(dut, ov, od, oc, rdy);
    if (x) begin
      if (sbq.size() == 0) begin
        chk({nm, " scoreboard empty"}, 32'd0, 32'd1);
      end else begin
        e = sbq.pop_front();
        m_v = 1'b1;
        m_d = e.d;
        m_c = e.ch;
      end
    end else if (orr) begin
      m_v = 1'b0;
    end
    chk({nm, " out_valid"}, ov, m_v);
    chk({nm, " out_data"}, od, m_d);
    chk({nm, " out_chan"}, oc, m_c);
  endtask

  // Entered just after a rising edge; returns just after the next one.
  task automatic apply_vec(input vec_t t, input int idx);
    logic ov; logic [7:0] od; logic [1:0] oc; logic [3:0] rdy;
    exp_t e;
    if (t.rb) do_reset(t.dut);
    mode = t.md; sel = t.sel; v = t.v; ordy = t.ordy; d4_d0 = t.d0;
    #3;
    read_out(t.dut, ov, od, oc, rdy);
    chk($sformatf("v%0d in_ready", idx), rdy, t.rdy);
    if (t.x) begin
      e.ch = t.ch;
      e.d  = t.d;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    post_edge(t.dut, t.x, t.ordy, $sformatf("v%0d", idx));
  endtask

  initial begin
    logic ov; logic [7:0] od; logic [1:0] oc; logic [3:0] rdy;
    rst = 1'b1; mode = 1'b0; sel = 2'd0; v = 4'h0; ordy = 1'b0; d4_d0 = 8'hA0;
    model_clear();

    // 2:1 compatibility, fixed select.
    tbl.push_back(mk(2, 1, 0, 0, 4'b0011, 1, 4'b0001, 1, 0, 8'h01, 8'hA0));
    tbl.push_back(mk(2, 0, 0, 1, 4'b0011, 1, 4'b0010, 1, 1, 8'h00, 8'hA0));
    tbl.push_back(mk(2, 0, 0, 0, 4'b0000, 1, 4'b0001, 0, 0, 8'h00, 8'hA0));
    // N=3: out-of-range select, fixed-mode grants leave the pointer alone.
    tbl.push_back(mk(3, 1, 1, 0, 4'b0111, 1, 4'b0001, 1, 0, 8'hC0, 8'hA0));
    tbl.push_back(mk(3, 0, 1, 0, 4'b0111, 1, 4'b0010, 1, 1, 8'hC1, 8'hA0));
    tbl.push_back(mk(3, 0, 0, 3, 4'b0111, 1, 4'b0000, 0, 0, 8'h00, 8'hA0));
    tbl.push_back(mk(3, 0, 0, 3, 4'b0111, 1, 4'b0000, 0, 0, 8'h00, 8'hA0));
    tbl.push_back(mk(3, 0, 0, 0, 4'b0111, 1, 4'b0001, 1, 0, 8'hC0, 8'hA0));
    tbl.push_back(mk(3, 0, 1, 0, 4'b0111, 1, 4'b0100, 1, 2, 8'hC2, 8'hA0));
    tbl.push_back(mk(3, 0, 1, 0, 4'b0111, 1, 4'b0001, 1, 0, 8'hC0, 8'hA0));
    // N=4 round-robin fairness with all channels requesting.
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk(4, (i == 0), 1, 0, 4'b1111, 1, 4'(1 << (i % 4)), 1,
                       2'(i % 4), 8'(8'hA0 + (i % 4)), 8'hA0));
    end
    // Sparse requests on channels 1 and 3, then channel 3 drops for one cycle.
    tbl.push_back(mk(4, 0, 1, 0, 4'b1010, 1, 4'b0010, 1, 1, 8'hA1, 8'hA0));
    tbl.push_back(mk(4, 0, 1, 0, 4'b1010, 1, 4'b1000, 1, 3, 8'hA3, 8'hA0));
    tbl.push_back(mk(4, 0, 1, 0, 4'b1010, 1, 4'b0010, 1, 1, 8'hA1, 8'hA0));
    tbl.push_back(mk(4, 0, 1, 0, 4'b1010, 1, 4'b1000, 1, 3, 8'hA3, 8'hA0));
    tbl.push_back(mk(4, 0, 1, 0, 4'b1010, 1, 4'b0010, 1, 1, 8'hA1, 8'hA0));
    tbl.push_back(mk(4, 0, 1, 0, 4'b0010, 1, 4'b0010, 1, 1, 8'hA1, 8'hA0));
    tbl.push_back(mk(4, 0, 1, 0, 4'b1010, 1, 4'b1000, 1, 3, 8'hA3, 8'hA0));
    // Backpressure: load 8'h55, stall 5 cycles, then release.
    tbl.push_back(mk(4, 0, 1, 0, 4'b1111, 1, 4'b0001, 1, 0, 8'h55, 8'h55));
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mk(4, 0, 1, 0, 4'b1111, 0, 4'b0000, 0, 0, 8'h00, 8'h55));
    end
    tbl.push_back(mk(4, 0, 1, 0, 4'b1111, 1, 4'b0010, 1, 1, 8'hA1, 8'hA0));
    tbl.push_back(mk(4, 0, 1, 0, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 8'hA0));

    @(posedge clk); #1;
    foreach (tbl[i]) apply_vec(tbl[i], i);

    // Async reset between edges while a word is held.
    apply_vec(mk(4, 0, 1, 0, 4'b1111, 1, 4'b0100, 1, 2, 8'hA2, 8'hA0), 100);
    #2;
    rst = 1'b1;
    #1;
    read_out(4, ov, od, oc, rdy);
    chk("async rst out_valid", ov, 1'b0);
    chk("async rst out_data", od, 8'h00);
    chk("async rst out_chan", oc, 2'd0);
    chk("async rst in_ready", rdy, 4'b0000);
    v = 4'h0;
    #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    apply_vec(mk(4, 0, 1, 0, 4'b1111, 1, 4'b0001, 1, 0, 8'hA0, 8'hA0), 101);
    apply_vec(mk(4, 0, 1, 0, 4'b1111, 1, 4'b0010, 1, 1, 8'hA1, 8'hA0), 102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
